// File: rtl/uart_pkg.sv
// Shared UART definitions: ASCII constants, transmit FSM states and the nibble-to-hex encoder.
// Kept generic so a receive-side command parser can reuse it.
package uart_pkg;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_0  = 8'h30;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_FRAME, S_NEXT, S_DONE} state_e;

  function automatic logic [7:0] hex_to_ascii(input logic [3:0] nibble, input logic upper);
    if (nibble < 4'd10) return ASCII_0 + {4'h0, nibble};
    return (upper ? 8'h37 : 8'h57) + {4'h0, nibble};
  endfunction

endpackage

// File: rtl/uart_hex_tx_if.sv
// Request/status bundle between the hash core (master) and the hex transmitter (slave).
interface uart_hex_tx_if #(parameter int DIGEST_W = 256);
  logic                Start;
  logic [DIGEST_W-1:0] Digest;
  logic                Busy;
  logic                TxOut;
  logic                TxDone;

  modport master (output Start, Digest, input Busy, TxOut, TxDone);
  modport slave  (input Start, Digest, output Busy, TxOut, TxDone);
endinterface

// File: rtl/uart_byte_frame.sv
// Serialises one byte as start bit, 8 data bits LSB first and STOP_BITS stop bits.
// Baud counter restarts on every Load so the start bit is always a full DIV cycles.
module uart_byte_frame #(
  parameter int DIV       = 16,
  parameter int STOP_BITS = 1
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Load,
  input  logic [7:0] Data,
  output logic       TxOut,
  output logic       FrameDone
);
  localparam int NBITS = 9 + STOP_BITS;
  localparam int BW    = (DIV > 1) ? $clog2(DIV) : 1;

  logic [NBITS-1:0] sr_q;
  logic [3:0]       bit_q;
  logic [BW-1:0]    baud_q;
  logic             active_q;
  logic             bit_end;

  assign bit_end   = (baud_q == BW'(DIV - 1));
  // Asserted during the final cycle of the last stop bit so the next Load can follow after one idle cycle.
  assign FrameDone = active_q && bit_end && (bit_q == 4'(NBITS - 1));
  assign TxOut     = active_q ? sr_q[0] : 1'b1;

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      sr_q     <= '1;
      bit_q    <= '0;
      baud_q   <= '0;
      active_q <= 1'b0;
    end else if (Load) begin
      sr_q     <= {{STOP_BITS{1'b1}}, Data, 1'b0};
      bit_q    <= '0;
      baud_q   <= '0;
      active_q <= 1'b1;
    end else if (active_q) begin
      if (bit_end) begin
        baud_q <= '0;
        if (bit_q == 4'(NBITS - 1)) begin
          active_q <= 1'b0;
        end else begin
          bit_q <= bit_q + 4'd1;
          sr_q  <= {1'b1, sr_q[NBITS-1:1]};
        end
      end else begin
        baud_q <= baud_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_hex_tx.sv
// Sends a latched DIGEST_W-bit hash as ASCII hex, MSB nibble first, plus optional CR/LF.
// FSM sequences bytes; uart_byte_frame handles the bit timing.
module uart_hex_tx
  import uart_pkg::*;
#(
  parameter int DIGEST_W  = 256,
  parameter int CLK_HZ    = 50_000_000,
  parameter int BAUD      = 115200,
  parameter int UPPERCASE = 1,
  parameter int EOL_MODE  = 2,
  parameter int STOP_BITS = 1
) (
  input  logic          Clk,
  input  logic          Reset,
  uart_hex_tx_if.slave  bus
);
  localparam int         DIV  = (CLK_HZ + BAUD / 2) / BAUD;
  localparam int         NNIB = DIGEST_W / 4;
  localparam int         NW   = $clog2(NNIB + 1);
  localparam logic [1:0] NEOL = (EOL_MODE == 2) ? 2'd2 : (EOL_MODE == 1) ? 2'd1 : 2'd0;

  state_e              state_q, state_d;
  logic [DIGEST_W-1:0] dig_q, dig_d;
  logic [NW-1:0]       nib_q, nib_d;
  logic [1:0]          eol_q, eol_d;
  logic [7:0]          byte_q, byte_d;
  logic                load_q, load_d;
  logic                frame_done;

  // Digest nibbles first; once exhausted the remaining EOL count picks CR (2 left) or LF (1 left).
  function automatic logic [7:0] pick(input logic [NW-1:0] nib, input logic [1:0] eol,
                                      input logic [3:0] top);
    if (nib != '0)     return hex_to_ascii(top, UPPERCASE != 0);
    if (eol == 2'd2)   return ASCII_CR;
    return ASCII_LF;
  endfunction

  always_comb begin
    state_d = state_q;
    dig_d   = dig_q;
    nib_d   = nib_q;
    eol_d   = eol_q;
    byte_d  = byte_q;
    load_d  = 1'b0;
    case (state_q)
      S_IDLE: if (bus.Start) begin
        dig_d   = bus.Digest;
        nib_d   = NW'(NNIB);
        eol_d   = NEOL;
        state_d = S_LOAD;
      end
      S_LOAD: begin
        byte_d  = pick(nib_q, eol_q, dig_q[DIGEST_W-1 -: 4]);
        load_d  = 1'b1;
        state_d = S_FRAME;
      end
      S_FRAME: if (frame_done) begin
        if (nib_q != '0) begin
          dig_d = dig_q << 4;
          nib_d = nib_q - 1'b1;
        end else if (eol_q != 2'd0) begin
          eol_d = eol_q - 2'd1;
        end
        // The next byte is registered here so the framer starts it after exactly one idle cycle.
        if (nib_d != '0 || eol_d != 2'd0) begin
          byte_d  = pick(nib_d, eol_d, dig_d[DIGEST_W-1 -: 4]);
          load_d  = 1'b1;
          state_d = S_NEXT;
        end else begin
          state_d = S_DONE;
        end
      end
      S_NEXT:  state_d = S_FRAME;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q <= S_IDLE;
      dig_q   <= '0;
      nib_q   <= '0;
      eol_q   <= '0;
      byte_q  <= '0;
      load_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dig_q   <= dig_d;
      nib_q   <= nib_d;
      eol_q   <= eol_d;
      byte_q  <= byte_d;
      load_q  <= load_d;
    end
  end

  assign bus.Busy   = (state_q != S_IDLE);
  assign bus.TxDone = (state_q == S_DONE);

  uart_byte_frame #(.DIV(DIV), .STOP_BITS(STOP_BITS)) u_frame (
    .Clk       (Clk),
    .Reset     (Reset),
    .Load      (load_q),
    .Data      (byte_q),
    .TxOut     (bus.TxOut),
    .FrameDone (frame_done)
  );

endmodule

// File: tb/tb_uart_hex_tx.sv
// Directed and random transfers on four configurations; a trace-based UART decoder is compared
// with an expected byte string built from the hex/EOL rules.
module tb_uart_hex_tx;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_hex_tx_if #(.DIGEST_W(16))  b0 ();
  uart_hex_tx_if #(.DIGEST_W(16))  b1 ();
  uart_hex_tx_if #(.DIGEST_W(256)) b2 ();
  uart_hex_tx_if #(.DIGEST_W(256)) b3 ();

  uart_hex_tx #(.DIGEST_W(16), .CLK_HZ(16), .BAUD(1), .UPPERCASE(1), .EOL_MODE(2), .STOP_BITS(1))
    d0 (.Clk(clk), .Reset(rst_n), .bus(b0));
  uart_hex_tx #(.DIGEST_W(16), .CLK_HZ(16), .BAUD(1), .UPPERCASE(0), .EOL_MODE(0), .STOP_BITS(2))
    d1 (.Clk(clk), .Reset(rst_n), .bus(b1));
  uart_hex_tx #(.DIGEST_W(256), .CLK_HZ(16), .BAUD(1), .UPPERCASE(1), .EOL_MODE(2), .STOP_BITS(1))
    d2 (.Clk(clk), .Reset(rst_n), .bus(b2));
  uart_hex_tx #(.DIGEST_W(256), .CLK_HZ(50_000_000), .BAUD(115200), .UPPERCASE(1), .EOL_MODE(2),
                .STOP_BITS(1))
    d3 (.Clk(clk), .Reset(rst_n), .bus(b3));

  localparam logic [255:0] SHA_ABC =
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic line_of(input int i);
    case (i)
      0: return b0.TxOut;
      1: return b1.TxOut;
      2: return b2.TxOut;
      default: return b3.TxOut;
    endcase
  endfunction

  function automatic logic busy_of(input int i);
    case (i)
      0: return b0.Busy;
      1: return b1.Busy;
      2: return b2.Busy;
      default: return b3.Busy;
    endcase
  endfunction

  function automatic logic done_of(input int i);
    case (i)
      0: return b0.TxDone;
      1: return b1.TxDone;
      2: return b2.TxDone;
      default: return b3.TxDone;
    endcase
  endfunction

  task automatic drive(input int i, input logic s, input logic [255:0] d);
    case (i)
      0: begin b0.Start = s; b0.Digest = d[15:0]; end
      1: begin b1.Start = s; b1.Digest = d[15:0]; end
      2: begin b2.Start = s; b2.Digest = d; end
      default: begin b3.Start = s; b3.Digest = d; end
    endcase
  endtask

  // mode 0: drop Start after acceptance; 1: hold Start (Digest all ones) until TxDone;
  // 2: hold Start through TxDone for a back-to-back follow-up. nb_lim < byte count decodes a prefix only.
  task automatic xfer(input int i, input logic [255:0] dig, input int w, input int div,
                      input int stop, input int eol, input bit upper, input int mode,
                      input int nb_lim, input string tag, output int acc, output int tdone);
    logic [7:0]   exp[$];
    bit           tr[$];
    logic [255:0] sh;
    logic [7:0]   got;
    int F, N, nb, t, lim, p, prev, nib;
    bit ok;
    for (int k = 0; k < w / 4; k++) begin
      sh  = dig >> (w - 4 - 4 * k);
      nib = int'(sh[3:0]);
      exp.push_back(nib < 10 ? 8'(48 + nib) : 8'((upper ? 65 : 97) + nib - 10));
    end
    if (eol == 2) exp.push_back(8'h0D);
    if (eol >= 1) exp.push_back(8'h0A);
    N  = exp.size();
    F  = div * (9 + stop);
    nb = (nb_lim < N) ? nb_lim : N;

    drive(i, 1'b1, dig);
    t = 0;
    do begin @(negedge clk); t++; end while (!busy_of(i) && t < 4);
    chk({tag, "/accept"}, int'(busy_of(i)), 1);
    acc = cyc;
    drive(i, mode != 0, (mode != 0) ? '1 : ~dig);

    lim = (nb < N) ? 2 + nb * (F + 1) : 2 + N * (F + 1) + 20;
    tdone = -1;
    tr.push_back(line_of(i));
    for (int c = 1; c < lim && tdone < 0; c++) begin
      @(negedge clk);
      tr.push_back(line_of(i));
      if (done_of(i)) begin
        tdone = c;
        chk({tag, "/busy_at_done"}, int'(busy_of(i)), 1);
        if (mode == 1) drive(i, 1'b0, dig);
      end
    end

    p = 0;
    prev = 0;
    for (int b = 0; b < nb; b++) begin
      while (p < tr.size() && tr[p]) p++;
      if (p + F >= tr.size()) begin
        chk({tag, "/missing_byte"}, b, nb);
        break;
      end
      if (b == 0) chk({tag, "/first_start"}, p, 2);
      else        chk({tag, "/byte_spacing"}, p - prev, F + 1);
      got = '0;
      for (int j = 0; j < 8; j++) got[j] = tr[p + div * (1 + j) + div / 2];
      chk($sformatf("%s/byte%0d", tag, b), int'(got), int'(exp[b]));
      ok = tr[p + F];
      for (int s = 0; s < stop; s++) ok &= tr[p + div * (9 + s) + div / 2];
      chk($sformatf("%s/stop_gap%0d", tag, b), int'(ok), 1);
      prev = p;
      p    = p + F;
    end

    if (nb == N) begin
      chk({tag, "/done_cycle"}, tdone, 2 + N * F + N - 1);
      if (mode != 2) begin
        repeat (2) begin
          @(negedge clk);
          chk({tag, "/after_done"}, int'({line_of(i), busy_of(i), done_of(i)}), 4);
        end
      end
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int a1, n1, a2, n2, bad;
    logic [255:0] r;
    for (int i = 0; i < 4; i++) drive(i, 1'b0, '0);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++)
      chk($sformatf("reset%0d", i), int'({line_of(i), busy_of(i), done_of(i)}), 4);
    rst_n = 1'b1;
    @(negedge clk);

    xfer(0, 256'hA5F0, 16, 16, 1, 2, 1, 0, 99, "t1_upper_crlf", a1, n1);
    xfer(1, 256'hA5F0, 16, 16, 2, 0, 0, 0, 99, "t2_lower_stop2", a1, n1);
    repeat (2) begin
      r = 256'($urandom);
      xfer(0, r, 16, 16, 1, 2, 1, 0, 99, "rand_d0", a1, n1);
      r = 256'($urandom);
      xfer(1, r, 16, 16, 2, 0, 0, 0, 99, "rand_d1", a1, n1);
    end

    xfer(0, 256'h1234, 16, 16, 1, 2, 1, 1, 99, "t3_start_while_busy", a1, n1);

    r = 256'($urandom);
    xfer(0, r, 16, 16, 1, 2, 1, 2, 99, "b2b_first", a1, n1);
    r = 256'($urandom);
    xfer(0, r, 16, 16, 1, 2, 1, 0, 99, "b2b_second", a2, n2);
    chk("b2b_idle_gap", a2 - (a1 + n1), 2);

    // Reset in the middle of data bit 3 of the second byte ('E' = 0x45, bit 3 = 0).
    drive(0, 1'b1, 256'hBEEF);
    @(negedge clk);
    drive(0, 1'b0, '0);
    repeat (2 + 161 + 16 * 4 + 8) @(negedge clk);
    chk("t4_mid_bit3", int'(line_of(0)), 0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("t4_reset_state", int'({line_of(0), busy_of(0), done_of(0)}), 4);
    rst_n = 1'b1;
    bad = 0;
    repeat (3 * 160) begin
      @(negedge clk);
      if (!line_of(0) || busy_of(0) || done_of(0)) bad++;
    end
    chk("t4_quiet_after_reset", bad, 0);
    xfer(0, 256'hBEEF, 16, 16, 1, 2, 1, 0, 99, "t4_after_reset", a1, n1);

    xfer(2, SHA_ABC, 256, 16, 1, 2, 1, 0, 99, "t6_sha_abc", a1, n1);
    xfer(3, SHA_ABC, 256, 434, 1, 2, 1, 0, 2, "t6_div434", a1, n1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("t6_reset_state", int'({line_of(3), busy_of(3), done_of(3)}), 4);
    rst_n = 1'b1;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
